// File: rtl/sid_note_sequencer.sv
// Note-on/note-off command sequencer driving the SID register write port with setup/strobe/hold cycles.
// Optional macro SID_SEQ_RETRIG_EN: prefix a gate-off write when a note-on hits a gated voice.
`timescale 1ns/1ps

module sid_note_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_note_on,
  input  logic [1:0] cmd_voice,
  input  logic [7:0] cmd_freq,
  input  logic [7:0] cmd_atk,
  input  logic [7:0] cmd_sus,
  input  logic [7:0] cmd_wave,
  output logic [2:0] sid_addr,
  output logic [1:0] sid_voice,
  output logic [7:0] sid_data,
  output logic       sid_we,
  output logic [3:0] gate_state
);

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned VOICE_W = 2;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NVOICE  = 4;
  localparam int unsigned IDX_W   = 3;

  localparam logic [ADDR_W-1:0] ADDR_FREQ = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ATK  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_SUS  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_WAV  = ADDR_W'(6);
  localparam logic [DATA_W-1:0] GATE      = DATA_W'(8'h01);

  // Write slots: 0..3 are the note-on list, 4 is the gate-off WAV write (note-off or retrigger prefix)
  localparam logic [IDX_W-1:0] IDX_FREQ    = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ATK     = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_SUS     = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_WAV_ON  = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_WAV_OFF = IDX_W'(4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef struct packed {
    logic               note_on;
    logic [VOICE_W-1:0] voice;
    logic [DATA_W-1:0]  freq;
    logic [DATA_W-1:0]  atk;
    logic [DATA_W-1:0]  sus;
    logic [DATA_W-1:0]  wave;
    logic [DATA_W-1:0]  off;
  } cmd_t;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  cmd_t               cmd_q, cmd_d;
  logic [DATA_W-1:0]  shadow_q [NVOICE];
  logic [DATA_W-1:0]  shadow_d [NVOICE];
  logic [NVOICE-1:0]  gate_q, gate_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [VOICE_W-1:0] bvoice_q, bvoice_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               we_q, we_d;
  logic               ready_q, ready_d;
  logic               retrig_c;

`ifdef SID_SEQ_RETRIG_EN
  assign retrig_c = cmd_note_on & gate_q[cmd_voice];
`else
  assign retrig_c = 1'b0;
`endif

  // Next-state, write-list sequencing and registered bus values
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    shadow_d = shadow_q;
    gate_d   = gate_q;
    addr_d   = addr_q;
    bvoice_d = bvoice_q;
    data_d   = data_q;
    we_d     = 1'b0;
    ready_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d.note_on = cmd_note_on;
          cmd_d.voice   = cmd_voice;
          cmd_d.freq    = cmd_freq;
          cmd_d.atk     = cmd_atk;
          cmd_d.sus     = cmd_sus;
          cmd_d.wave    = cmd_wave;
          cmd_d.off     = shadow_q[cmd_voice] & ~GATE;
          if (cmd_note_on) begin
            shadow_d[cmd_voice] = cmd_wave & ~GATE;
          end
          idx_d   = (!cmd_note_on || retrig_c) ? IDX_WAV_OFF : IDX_FREQ;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (idx_q == IDX_WAV_OFF) begin
          gate_d[cmd_q.voice] = 1'b0;
          if (cmd_q.note_on) begin
            idx_d   = IDX_FREQ;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (idx_q == IDX_WAV_ON) begin
          gate_d[cmd_q.voice] = 1'b1;
          state_d             = ST_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SETUP;
        end
      end
    endcase

    we_d    = (state_d == ST_STROBE);
    ready_d = (state_d == ST_IDLE);

    // Bus is loaded entering SETUP and then held until the next write
    if (state_d == ST_SETUP) begin
      bvoice_d = cmd_d.voice;
      case (idx_d)
        IDX_FREQ: begin addr_d = ADDR_FREQ; data_d = cmd_d.freq;        end
        IDX_ATK:  begin addr_d = ADDR_ATK;  data_d = cmd_d.atk;         end
        IDX_SUS:  begin addr_d = ADDR_SUS;  data_d = cmd_d.sus;         end
        IDX_WAV_ON: begin addr_d = ADDR_WAV; data_d = cmd_d.wave | GATE; end
        default:  begin addr_d = ADDR_WAV;  data_d = cmd_d.off;         end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cmd_q    <= '0;
      shadow_q <= '{default: '0};
      gate_q   <= '0;
      addr_q   <= '0;
      bvoice_q <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cmd_q    <= cmd_d;
      shadow_q <= shadow_d;
      gate_q   <= gate_d;
      addr_q   <= addr_d;
      bvoice_q <= bvoice_d;
      data_q   <= data_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign sid_addr   = addr_q;
  assign sid_voice  = bvoice_q;
  assign sid_data   = data_q;
  assign sid_we     = we_q;
  assign gate_state = gate_q;

endmodule

// File: doc/sid_note_sequencer.md
# sid_note_sequencer

Command-level controller that sits in front of the `tt_um_sid` register write port. It converts note-on and note-off commands into the exact SID register write sequence: frequency, attack, sustain, then waveform with gate. Each write is driven with the setup/strobe/hold protocol the SID register file requires. The block frees the host (SPI bridge or on-chip pattern player) from cycle-level bus handling, and keeps a per-voice shadow of waveform and gate.

## Interface
- No parameters.
- `clk` in 1: system clock (5 MHz nominal).
- `rst_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command. High only in IDLE.
- `cmd_note_on` in 1: 1 = note-on, 0 = note-off.
- `cmd_voice` in 2: target voice, 0..3.
- `cmd_freq` in 8: frequency register value. Used by note-on only.
- `cmd_atk` in 8: attack register value. Used by note-on only.
- `cmd_sus` in 8: sustain register value. Used by note-on only.
- `cmd_wave` in 8: waveform bits. Bit 0 (GATE) is ignored. Used by note-on only.
- `sid_addr` out 3: SID register address.
- `sid_voice` out 2: SID voice select.
- `sid_data` out 8: SID write data.
- `sid_we` out 1: SID write strobe.
- `gate_state` out 4: per-voice gate shadow, bit n = voice n.

## Operation
- Register addresses: FREQ=0, ATK=4, SUS=5, WAV=6. GATE=8'h01.
- States: IDLE, SETUP, STROBE, HOLD.
- The handshake completes on a `clk` edge where `cmd_valid & cmd_ready` are both high. All cmd_* fields are captured on that edge.
- **Note-on write list, in order:**
  - (FREQ, `cmd_freq`)
  - (ATK, `cmd_atk`)
  - (SUS, `cmd_sus`)
  - (WAV, `cmd_wave` | GATE)
- **Note-off write list:** a single write (WAV, `wave_shadow[v]` & ~GATE).
- **Shadow updates:**
  - Note-on: `wave_shadow[v]` ← `cmd_wave` & ~GATE. This is updated at accept.
  - `gate_state[v]` is set at the end of the HOLD cycle of the final WAV write for note-on, and cleared at the same point for note-off.
- **One write:**
  - SETUP: addr/voice/data driven, `sid_we`=0.
  - STROBE: same bus values, `sid_we`=1.
  - HOLD: same bus values, `sid_we`=0.
- **Sequencing:** a 3-bit write index steps through the list. After the HOLD of the last write, the state returns to IDLE. Otherwise it goes to SETUP of the next write.
- **Bus in IDLE:** `sid_addr`, `sid_voice` and `sid_data` keep the last driven values. `sid_we` is 0.
- **Repeat commands:**
  - Note-off to a voice whose gate is already clear still issues its write.
  - Note-on to a voice whose gate is already set re-issues the full list (see Configuration for retrigger).
- Voice 3 is handled like voices 0..2; the SID decodes or ignores it.

## Timing
- **Reset values:**
  - State = IDLE, `cmd_ready`=1.
  - `sid_we`=0, `sid_addr`=0, `sid_voice`=0, `sid_data`=0.
  - `gate_state`=0, all `wave_shadow`=0.
- **Latency:**
  - SETUP of the first write is the cycle immediately after accept.
  - Note-on occupies 12 cycles (4 writes × 3). Note-off occupies 3 cycles.
  - `cmd_ready` rises in the cycle after the last HOLD.
- `sid_we` is high for exactly one cycle per write. Bus values are stable from SETUP through HOLD.
- Minimum command-to-command spacing is 13 cycles for note-on and 4 cycles for note-off. Back-to-back commands never overlap writes.
- `cmd_valid` held high while `cmd_ready`=0 is not consumed. The fields may change freely until accept.
- Asserting `rst_n` mid-sequence aborts immediately:
  - `sid_we` drops asynchronously.
  - The state goes to IDLE and no remaining writes are issued.
  - `gate_state` and the shadows clear.

## Configuration
- `SID_SEQ_RETRIG_EN` defined:
  - A note-on to voice v with `gate_state[v]`=1 is prefixed with (WAV, old `wave_shadow[v]` & ~GATE). This gives 5 writes and 15 cycles.
  - `gate_state[v]` clears after the prefix HOLD, then sets after the final WAV HOLD.
  - This forces an ADSR restart.
- `SID_SEQ_RETRIG_EN` undefined: every note-on is exactly 4 writes, regardless of gate state.

## Test plan
- **Reset:** hold `rst_n`=0 for 100 cycles, then release.
  - Expect all outputs at reset values and `cmd_ready`=1.
  - Expect no `sid_we` pulse for 50 idle cycles.
- **Note-on voice 0:** freq=17, atk=8'h00, sus=8'h0F, wave=8'h10 (wave bit 0 is ignored).
  - Expect exactly 4 single-cycle `sid_we` pulses at accept+2, +5, +8, +11.
  - Expect the writes (0,0,17), (4,0,0x00), (5,0,0x0F), (6,0,0x11).
  - Expect `gate_state`=4'b0001 and `cmd_ready`=1 at accept+13.
- **Note-off voice 0** after the previous case:
  - Expect one write (6,0,0x10) at accept+2.
  - Expect `gate_state`=0 at accept+4.
- **Back-to-back:** note-on voice 2 immediately followed by note-off voice 1, with `cmd_valid` held high.
  - Expect the second accept exactly 13 cycles after the first.
  - Expect 5 total strobes, none adjacent.
- **Retrigger:** note-on voice 1 with wave=8'h20, then note-on voice 1 with wave=8'h40.
  - With `SID_SEQ_RETRIG_EN`, the second command's first write is (6,1,0x20), followed by the 4-write list ending (6,1,0x41).
  - Without the macro, the second command writes only the 4-write list.
- **Reset mid-sequence:** assert `rst_n`=0 during the STROBE of the 2nd note-on write.
  - Expect `sid_we`=0 within the same cycle.
  - Expect no further strobes after release, `gate_state`=0 and `cmd_ready`=1.
